zigzag_rd_addr_gen: RTL and testbench
=====================================

Name: zigzag_rd_addr_gen

Overview:
- Read-address generator for an 8x8 coefficient buffer, for example after the DCT/quantiser stage.
- On a one-cycle start pulse it emits all ROW*COL buffer addresses in JPEG zigzag order, one per clock, qualified by valid.
- Pulses done with the final address.
- Pure address sequencer; it does not touch data.

Parameters:
- WIDTH, 16: word width of the addressed buffer. Carried for interface consistency only; it does not affect address width or sequence.
- ROW, 8: block rows (y dimension). Must be a power of two, >= 2.
- COL, 8: block columns (x dimension). Must be a power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin one block scan; sampled on rising clk.
- done  out  1  one-cycle pulse, high together with the last valid address.
- valid  out  1  high while addr carries a sequence address.
- addr  out  $clog2(ROW)+$clog2(COL)  buffer address, = y*COL + x (row-major). Defaults give 6 bits.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: valid=0, done=0, addr=0, x=0, y=0, direction=UP, state=IDLE. Reset asserted mid-scan aborts immediately; no done is produced.
- States:
  - IDLE: outputs held at reset values. start=1 goes to SCAN, loading x=0, y=0, dir=UP.
  - SCAN: each cycle drives valid=1 and addr=y*COL+x, then advances (x,y).
- Latency: start sampled high at edge N gives the first valid (addr 0) in the cycle after edge N. Exactly ROW*COL consecutive valid cycles follow, with no gaps.
- All outputs are registered; no combinational path from start to the outputs.
- Advance rules, UP direction (moving up-right):
  - if x==COL-1: y++, dir=DOWN;
  - else if y==0: x++, dir=DOWN;
  - else: x++, y--.
- Advance rules, DOWN direction (moving down-left):
  - if y==ROW-1: x++, dir=UP;
  - else if x==0: y++, dir=UP;
  - else: x--, y++.
- Corner priority: the edge tests above are evaluated in the listed order. This gives the standard zigzag at the corners (0,COL-1) and (ROW-1,0).
- Last element: x==COL-1 and y==ROW-1 gives done=1 with valid=1 and addr=ROW*COL-1. Next cycle returns to IDLE (valid=0, done=0, addr=0).
- start while in SCAN, including on the final cycle, is ignored. No queuing.
- A start in the first IDLE cycle after done begins a new scan.
- Back-to-back scans therefore have a minimum one-cycle gap with valid=0.
- addr arithmetic: y shifted left by $clog2(COL), OR'd with x. No overflow is possible.

Optional Feature:
- Macro: RD_ADDR_TRANSPOSE_EN.
- Defined: addr = x*ROW + y (column-major), i.e. zigzag over the transposed block. It serves buffers written column-wise by the 1-D DCT second pass. Sequence length, timing, valid and done are unchanged.
- Undefined: addr = y*COL + x as above.

Test Plan:
- Reset then idle: rst_n low for 5 ns, release, no start -> valid=0, done=0, addr=0 for 20 cycles.
- Single scan, defaults: start pulse 1 cycle -> next cycle valid=1, addr sequence begins 0,1,8,16,9,2,3,10,17,24; 64 consecutive valid cycles; ends 53,60,61,54,47,55,62,63; done=1 only with addr=63; valid=0 the following cycle.
- Start during scan: extra start pulses at element 10 and element 63 -> sequence unaffected, still exactly 64 addresses, single done.
- Reset mid-scan: assert rst_n low at element 20 -> valid, done and addr go to 0 immediately with no done; next start restarts at addr 0.
- Back-to-back: start in the cycle right after done -> second full 64-address scan identical to the first, after a one-cycle valid=0 gap.
- RD_ADDR_TRANSPOSE_EN defined: start -> sequence 0,8,1,2,9,16,24,17,10,3 ... ending 63; done timing identical.

Source files
------------

// File: rtl/zigzag_rd_addr_gen_if.sv
// -----------------------------------------------------------------------------
// zigzag_rd_addr_gen_if
// Request/address bus between a block consumer and the zigzag read-address
// generator. The generator side owns valid/done/addr and listens to start;
// the consumer side issues start and watches the address stream.
// -----------------------------------------------------------------------------
interface zigzag_rd_addr_gen_if #(
    parameter int ROW = 8,
    parameter int COL = 8
) ();

    localparam int AW = $clog2(ROW) + $clog2(COL);

    logic          start;
    logic          done;
    logic          valid;
    logic [AW-1:0] addr;

    // Address generator side.
    modport master (
        input  start,
        output done,
        output valid,
        output addr
    );

    // Consumer side: requests a scan and receives the address stream.
    modport slave (
        output start,
        input  done,
        input  valid,
        input  addr
    );

endinterface : zigzag_rd_addr_gen_if

// File: rtl/zigzag_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// zigzag_rd_addr_gen
// Read-address sequencer for a ROW x COL coefficient buffer. A one-cycle start
// launches a scan that emits every buffer address in JPEG zigzag order, one per
// clock, qualified by valid; done accompanies the final address.
//
// Build option: define RD_ADDR_TRANSPOSE_EN to address a column-major buffer
// (addr = x*ROW + y). Default is row-major (addr = y*COL + x). The visiting
// order, sequence length and handshake timing are identical in both builds.
// -----------------------------------------------------------------------------
module zigzag_rd_addr_gen #(
    parameter int WIDTH = 16,  // buffer word width, carried for consistency only
    parameter int ROW   = 8,   // block rows (y), power of two >= 2
    parameter int COL   = 8    // block columns (x), power of two >= 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    zigzag_rd_addr_gen_if.master    bus
);

    localparam int XW = $clog2(COL);
    localparam int YW = $clog2(ROW);
    localparam int AW = XW + YW;

    localparam logic [XW-1:0] X_ZERO = '0;
    localparam logic [YW-1:0] Y_ZERO = '0;
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_LAST = XW'(COL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROW - 1);

    // Elaboration-time parameter sanity checks.
    if ((ROW < 2) || ((ROW & (ROW - 1)) != 0)) begin : g_bad_row
        $error("zigzag_rd_addr_gen: ROW must be a power of two >= 2");
    end
    if ((COL < 2) || ((COL & (COL - 1)) != 0)) begin : g_bad_col
        $error("zigzag_rd_addr_gen: COL must be a power of two >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("zigzag_rd_addr_gen: WIDTH must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,   // moving up-right: x++, y--
        DIR_DOWN = 1'b1    // moving down-left: x--, y++
    } dir_e;

    state_e        state_q;
    dir_e          dir_q,   dir_d;
    logic [XW-1:0] x_q,     x_d;
    logic [YW-1:0] y_q,     y_d;
    logic          valid_q;
    logic          done_q,  done_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          at_last;

    // Buffer address of a block position; the only place the build option acts.
    function automatic logic [AW-1:0] pos_to_addr(input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y);
`ifdef RD_ADDR_TRANSPOSE_EN
        return {x, y};   // column-major: x*ROW + y
`else
        return {y, x};   // row-major:    y*COL + x
`endif
    endfunction

    // Next zigzag position from the current one; edge tests in priority order
    // so the corners (0,COL-1) and (ROW-1,0) turn the standard way.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        if (dir_q == DIR_UP) begin
            if (x_q == X_LAST) begin
                y_d   = y_q + Y_ONE;
                dir_d = DIR_DOWN;
            end else if (y_q == Y_ZERO) begin
                x_d   = x_q + X_ONE;
                dir_d = DIR_DOWN;
            end else begin
                x_d = x_q + X_ONE;
                y_d = y_q - Y_ONE;
            end
        end else begin
            if (y_q == Y_LAST) begin
                x_d   = x_q + X_ONE;
                dir_d = DIR_UP;
            end else if (x_q == X_ZERO) begin
                y_d   = y_q + Y_ONE;
                dir_d = DIR_UP;
            end else begin
                x_d = x_q - X_ONE;
                y_d = y_q + Y_ONE;
            end
        end
    end

    // Registered outputs describe the position about to be presented.
    assign addr_d  = pos_to_addr(x_d, y_d);
    assign done_d  = (x_d == X_LAST) && (y_d == Y_LAST);
    assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

    // Scan FSM: holds the presented position and drives all outputs from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            x_q     <= X_ZERO;
            y_q     <= Y_ZERO;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    dir_q  <= DIR_UP;
                    x_q    <= X_ZERO;
                    y_q    <= Y_ZERO;
                    done_q <= 1'b0;
                    addr_q <= '0;
                    if (bus.start) begin
                        state_q <= SCAN;
                        valid_q <= 1'b1;   // position (0,0) is presented first
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                SCAN: begin
                    // start is deliberately ignored for the whole scan.
                    if (at_last) begin
                        state_q <= IDLE;
                        dir_q   <= DIR_UP;
                        x_q     <= X_ZERO;
                        y_q     <= Y_ZERO;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        dir_q   <= dir_d;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        valid_q <= 1'b1;
                        done_q  <= done_d;
                        addr_q  <= addr_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign bus.valid = valid_q;
    assign bus.done  = done_q;
    assign bus.addr  = addr_q;

endmodule : zigzag_rd_addr_gen

// File: tb/tb_zigzag_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_zigzag_rd_addr_gen
// Directed bench for the 8x8 zigzag read-address generator. Expected addresses
// come from the hand-written JPEG zigzag table; with RD_ADDR_TRANSPOSE_EN the
// bench swaps the row/column fields of each table entry.
// -----------------------------------------------------------------------------
module tb_zigzag_rd_addr_gen;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int N   = ROW * COL;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // JPEG zigzag order for an 8x8 block, row-major addresses.
    int zz_tab [N] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    zigzag_rd_addr_gen_if #(.ROW(ROW), .COL(COL)) zz_if ();

    zigzag_rd_addr_gen #(
        .WIDTH (16),
        .ROW   (ROW),
        .COL   (COL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (zz_if)
    );

    // 10 ns clock; rising edges at 10, 20, ... so outputs are sampled on falling edges.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] exp_addr(input int idx);
        int a;
        a = zz_tab[idx];
`ifdef RD_ADDR_TRANSPOSE_EN
        return 6'(((a % COL) * ROW) + (a / COL));
`else
        return 6'(a);
`endif
    endfunction

    // One full scan: start pulse, N addresses with done only on the last, then
    // the mandatory idle gap. Extra starts are raised at element indices
    // extra_a / extra_b (use -1 for none).
    task automatic scan_body(input int extra_a, input int extra_b, input string tag);
        zz_if.start = 1'b1;
        @(negedge clk);
        zz_if.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (zz_if.valid !== 1'b1 || zz_if.addr !== exp_addr(i) ||
                zz_if.done !== (i == N - 1)) begin
                failures++;
                $display("FAIL %s elem %0d: valid=%b addr=%0d done=%b, expected valid=1 addr=%0d done=%b",
                         tag, i, zz_if.valid, zz_if.addr, zz_if.done, exp_addr(i), (i == N - 1));
            end
            zz_if.start = (i == extra_a) || (i == extra_b);
            @(negedge clk);
            zz_if.start = 1'b0;
        end
        checks++;
        if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0 || zz_if.addr !== 6'd0) begin
            failures++;
            $display("FAIL %s gap: valid=%b done=%b addr=%0d, expected 0/0/0",
                     tag, zz_if.valid, zz_if.done, zz_if.addr);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        zz_if.start = 1'b0;
        #2;
        checks++;
        if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0 || zz_if.addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_asserted: valid=%b done=%b addr=%0d, expected 0/0/0",
                     zz_if.valid, zz_if.done, zz_if.addr);
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0 || zz_if.addr !== 6'd0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: valid=%b done=%b addr=%0d, expected 0/0/0",
                         i, zz_if.valid, zz_if.done, zz_if.addr);
            end
        end
    endtask

    task automatic test_single_scan();
        scan_body(-1, -1, "single_scan");
    endtask

    task automatic test_start_during_scan();
        scan_body(10, N - 1, "start_during_scan");
        // A start on the final element must not have been queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0) begin
                failures++;
                $display("FAIL start_during_scan idle %0d: valid=%b done=%b, expected 0/0",
                         i, zz_if.valid, zz_if.done);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        zz_if.start = 1'b1;
        @(negedge clk);
        zz_if.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (zz_if.valid !== 1'b1 || zz_if.addr !== exp_addr(i) || zz_if.done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_scan elem %0d: valid=%b addr=%0d done=%b, expected 1/%0d/0",
                         i, zz_if.valid, zz_if.addr, zz_if.done, exp_addr(i));
            end
            @(negedge clk);
        end
        // Element 20 is on the bus now; reset must clear outputs without a clock.
        rst_n = 1'b0;
        #1;
        checks++;
        if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0 || zz_if.addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_mid_scan abort: valid=%b done=%b addr=%0d, expected 0/0/0",
                     zz_if.valid, zz_if.done, zz_if.addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (zz_if.valid !== 1'b0 || zz_if.done !== 1'b0 || zz_if.addr !== 6'd0) begin
                failures++;
                $display("FAIL reset_mid_scan idle %0d: valid=%b done=%b addr=%0d, expected 0/0/0",
                         i, zz_if.valid, zz_if.done, zz_if.addr);
            end
        end
        scan_body(-1, -1, "restart_after_reset");
    endtask

    task automatic test_back_to_back();
        // The second scan's start lands in the first idle cycle after done.
        scan_body(-1, -1, "b2b_first");
        scan_body(-1, -1, "b2b_second");
    endtask

    initial begin
        rst_n       = 1'b0;
        zz_if.start = 1'b0;
        test_reset();
        test_single_scan();
        test_start_during_scan();
        test_reset_mid_scan();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_zigzag_rd_addr_gen
